// File: rtl/gam_winner_search_pkg.sv
// Shared types and defaults for the GAM winner search.
// Holds the FSM state encoding and the squared-distance width helper.
package gam_winner_search_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ACC,
    S_CMP,
    S_DONE
  } state_t;

  localparam int DIM_DEF      = 4;
  localparam int ELEM_W_DEF   = 8;
  localparam int LANES_DEF    = 2;
  localparam int NODE_MAX_DEF = 8;

  // Wide enough for DIM squared differences of ELEM_W-bit elements.
  function automatic int ed_width(input int elem_w, input int dim);
    return 2 * elem_w + $clog2(dim);
  endfunction

endpackage

// File: rtl/gam_ed_lane_sum.sv
// Combinational sum of squared absolute differences across LANES element pairs.
// Used once per accumulate beat; no state, no latency.
module gam_ed_lane_sum #(
  parameter int LANES  = 2,
  parameter int ELEM_W = 8,
  parameter int SUM_W  = 18
) (
  input  logic [LANES*ELEM_W-1:0] x_lanes,
  input  logic [LANES*ELEM_W-1:0] n_lanes,
  output logic [SUM_W-1:0]        sum
);

  function automatic logic [2*ELEM_W-1:0] sq_diff(input logic [ELEM_W-1:0] a,
                                                 input logic [ELEM_W-1:0] b);
    logic [2*ELEM_W-1:0] d;
    d = (a > b) ? {{ELEM_W{1'b0}}, a - b} : {{ELEM_W{1'b0}}, b - a};
    return d * d;
  endfunction

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(sq_diff(x_lanes[i*ELEM_W +: ELEM_W], n_lanes[i*ELEM_W +: ELEM_W]));
    end
  end

endmodule

// File: rtl/gam_winner_search.sv
// Scans node memory for the two nodes nearest x_vec by squared Euclidean distance.
// Latency 1+N*(DIM/LANES+3) cycles; optional novelty flag under GAM_NOVELTY_EN.
module gam_winner_search
  import gam_winner_search_pkg::*;
#(
  parameter int DIM      = DIM_DEF,
  parameter int ELEM_W   = ELEM_W_DEF,
  parameter int LANES    = LANES_DEF,
  parameter int NODE_MAX = NODE_MAX_DEF,
  localparam int IDX_W   = $clog2(NODE_MAX),
  localparam int ED_W    = ed_width(ELEM_W, DIM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM*ELEM_W-1:0] x_vec,
  input  logic [IDX_W:0]        node_count,
  output logic                  mem_rd_en,
  output logic [IDX_W-1:0]      mem_rd_addr,
  input  logic [DIM*ELEM_W-1:0] mem_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      min1_node,
  output logic [IDX_W-1:0]      min2_node,
  output logic [ED_W-1:0]       min1_ed,
  output logic [ED_W-1:0]       min2_ed,
  output logic                  min1_valid,
  output logic                  min2_valid
`ifdef GAM_NOVELTY_EN
  ,
  input  logic [ED_W-1:0]       th_in,
  output logic                  novel
`endif
);

  localparam int BEATS     = DIM / LANES;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LANE_BITS = LANES * ELEM_W;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W:0]    NMAX      = (IDX_W + 1)'(NODE_MAX);

  state_t                state, state_nxt;
  logic [DIM*ELEM_W-1:0] x_reg, node_reg;
  logic [IDX_W:0]        n_reg, idx, count_clamped, idx_inc;
  logic [BEAT_W-1:0]     beat;
  logic [ED_W-1:0]       acc, lane_sum;

  assign count_clamped = (node_count > NMAX) ? NMAX : node_count;
  assign idx_inc       = idx + (IDX_W + 1)'(1);

  gam_ed_lane_sum #(
    .LANES (LANES),
    .ELEM_W(ELEM_W),
    .SUM_W (ED_W)
  ) u_lane_sum (
    .x_lanes(x_reg[beat*LANE_BITS +: LANE_BITS]),
    .n_lanes(node_reg[beat*LANE_BITS +: LANE_BITS]),
    .sum    (lane_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (count_clamped == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_ACC;
      S_ACC:   if (beat == BEAT_LAST) state_nxt = S_CMP;
      S_CMP:   state_nxt = (idx_inc < n_reg) ? S_FETCH : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    mem_rd_en   = (state == S_FETCH);
    mem_rd_addr = (state == S_FETCH) ? idx[IDX_W-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg      <= '0;
      node_reg   <= '0;
      n_reg      <= '0;
      idx        <= '0;
      beat       <= '0;
      acc        <= '0;
      min1_node  <= '0;
      min2_node  <= '0;
      min1_ed    <= '0;
      min2_ed    <= '0;
      min1_valid <= 1'b0;
      min2_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          x_reg      <= x_vec;
          n_reg      <= count_clamped;
          idx        <= '0;
          min1_node  <= '0;
          min2_node  <= '0;
          min1_ed    <= '1;
          min2_ed    <= '1;
          min1_valid <= 1'b0;
          min2_valid <= 1'b0;
        end
        S_WAIT: begin
          node_reg <= mem_rd_data;
          acc      <= '0;
          beat     <= '0;
        end
        S_ACC: begin
          acc  <= acc + lane_sum;
          beat <= beat + BEAT_W'(1);
        end
        S_CMP: begin
          idx <= idx_inc;
          // Strict compares: an equal later node never displaces an earlier one.
          if (acc < min1_ed) begin
            min2_node  <= min1_node;
            min2_ed    <= min1_ed;
            min2_valid <= min1_valid;
            min1_node  <= idx[IDX_W-1:0];
            min1_ed    <= acc;
            min1_valid <= 1'b1;
          end else if (acc < min2_ed) begin
            min2_node  <= idx[IDX_W-1:0];
            min2_ed    <= acc;
            min2_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GAM_NOVELTY_EN
  logic [ED_W-1:0] th_reg;
  logic            win_upd, win_valid;
  logic [ED_W-1:0] win_ed;

  // Look through the final CMP so novel is ready in the DONE cycle itself.
  assign win_upd   = (state == S_CMP) && (acc < min1_ed);
  assign win_valid = win_upd | min1_valid;
  assign win_ed    = win_upd ? acc : min1_ed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_reg <= '0;
      novel  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        th_reg <= th_in;
        novel  <= 1'b0;
      end
      if (state_nxt == S_DONE) begin
        novel <= (state == S_IDLE) ? 1'b1 : (!win_valid || (win_ed > th_reg));
      end
    end
  end
`endif

endmodule

// File: tb/tb_gam_winner_search.sv
// Table-driven bench for gam_winner_search with a scoreboard queue of expected results.
module tb_gam_winner_search;

  localparam int ED_W = 18;

  typedef struct packed {
    logic [31:0]      x;
    logic [7:0][31:0] nodes;
    logic [4:0]       n;
    logic [7:0]       lat;
    logic [17:0]      th;
    logic             v1;
    logic             v2;
    logic [2:0]       n1;
    logic [2:0]       n2;
    logic [17:0]      e1;
    logic [17:0]      e2;
    logic             nov;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x_vec = '0;
  logic [3:0]  node_count = '0;
  logic        mem_rd_en;
  logic [2:0]  mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic        busy, done;
  logic [2:0]  min1_node, min2_node;
  logic [17:0] min1_ed, min2_ed;
  logic        min1_valid, min2_valid;
`ifdef GAM_NOVELTY_EN
  logic [17:0] th_in = '0;
  logic        novel;
`endif

  gam_winner_search dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x_vec      (x_vec),
    .node_count (node_count),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .busy       (busy),
    .done       (done),
    .min1_node  (min1_node),
    .min2_node  (min2_node),
    .min1_ed    (min1_ed),
    .min2_ed    (min2_ed),
    .min1_valid (min1_valid),
    .min2_valid (min2_valid)
`ifdef GAM_NOVELTY_EN
    ,
    .th_in      (th_in),
    .novel      (novel)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [8];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int addr_q[$];
  always @(negedge clk) if (mem_rd_en) addr_q.push_back(int'(mem_rd_addr));

  vec_t sb_q[$];
  vec_t tbl[11];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic vec_t mk(input logic [31:0] x, input logic [7:0][31:0] nd, input int n,
                              input int lat, input int th, input bit v1, input int n1,
                              input int e1, input bit v2, input int n2, input int e2);
    vec_t v;
    v.x = x; v.nodes = nd; v.n = 5'(n); v.lat = 8'(lat); v.th = 18'(th);
    v.v1 = v1; v.n1 = 3'(n1); v.e1 = 18'(e1);
    v.v2 = v2; v.n2 = 3'(n2); v.e2 = 18'(e2);
    v.nov = !v1 || (e1 > th);
    return v;
  endfunction

  // Reference search: nearest and second-nearest with strict compares over clamped count.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int nn, ed, d, b1, b2, i1, i2;
    bit f1, f2;
    r = v; nn = (v.n > 8) ? 8 : int'(v.n);
    b1 = 262143; b2 = 262143; i1 = 0; i2 = 0; f1 = 0; f2 = 0;
    for (int k = 0; k < nn; k++) begin
      ed = 0;
      for (int e = 0; e < 4; e++) begin
        d = int'(v.x[e*8 +: 8]) - int'(v.nodes[k][e*8 +: 8]);
        ed += d * d;
      end
      if (ed < b1) begin
        b2 = b1; i2 = i1; f2 = f1; b1 = ed; i1 = k; f1 = 1;
      end else if (ed < b2) begin
        b2 = ed; i2 = k; f2 = 1;
      end
    end
    return mk(v.x, v.nodes, int'(v.n), 1 + 5 * nn, int'(v.th), f1, i1, b1, f2, i2, b2);
  endfunction

  task automatic run(input vec_t v, input bit inject, input string tag);
    int cyc, nn;
    bit seen, busy_ok, addr_ok;
    vec_t e;
    for (int k = 0; k < 8; k++) mem[k] = v.nodes[k];
    addr_q.delete();
    @(negedge clk);
    x_vec = v.x; node_count = v.n[3:0]; start = 1'b1;
`ifdef GAM_NOVELTY_EN
    th_in = v.th;
`endif
    sb_q.push_back(v);
    @(posedge clk); #1;
    start = 1'b0; x_vec = ~v.x;
    cyc = 1; seen = 0; busy_ok = 1;
    while (cyc <= 60) begin
      if (!busy) busy_ok = 0;
      if (done) begin seen = 1; break; end
      start = inject && (cyc == 3);
      if (start) node_count = 4'd1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_busy"}, busy_ok, 1);
    if (!seen) begin
      chk({tag, "_done_timeout"}, 0, 1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_latency"}, cyc, e.lat);
      chk({tag, "_min1_valid"}, min1_valid, e.v1);
      chk({tag, "_min2_valid"}, min2_valid, e.v2);
      chk({tag, "_min1_ed"}, min1_ed, e.e1);
      chk({tag, "_min2_ed"}, min2_ed, e.e2);
      if (e.v1) chk({tag, "_min1_node"}, min1_node, e.n1);
      if (e.v2) chk({tag, "_min2_node"}, min2_node, e.n2);
`ifdef GAM_NOVELTY_EN
      chk({tag, "_novel"}, novel, e.nov);
`endif
    end
    nn = (v.n > 8) ? 8 : int'(v.n);
    addr_ok = (addr_q.size() == nn);
    for (int k = 0; k < addr_q.size(); k++) if (addr_q[k] != k) addr_ok = 0;
    chk({tag, "_addr_seq"}, addr_ok, 1);
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, {busy, done}, 2'b00);
    chk({tag, "_hold_min1_ed"}, min1_ed, e.e1);
  endtask

  initial begin
    logic [7:0][31:0] nd;
    bit saw_done;

    nd = '0; nd[0] = p4(10,10,10,12); nd[1] = p4(10,10,10,10); nd[2] = p4(13,10,10,10);
    tbl[0] = mk(p4(10,10,10,10), nd, 3, 16, 0, 1, 1, 0, 1, 0, 4);
    nd = '0; nd[0] = p4(12,10,10,10); nd[1] = p4(10,8,10,10);
    tbl[1] = mk(p4(10,10,10,10), nd, 2, 11, 3, 1, 0, 4, 1, 1, 4);
    tbl[2] = mk(p4(10,10,10,10), nd, 2, 11, 4, 1, 0, 4, 1, 1, 4);
    tbl[3] = mk(p4(10,10,10,10), nd, 0, 1, 0, 0, 0, 262143, 0, 0, 262143);
    nd = '0; nd[0] = p4(11,12,13,14);
    tbl[4] = mk(p4(10,10,10,10), nd, 1, 6, 0, 1, 0, 30, 0, 0, 262143);
    nd = '0; nd[0] = p4(0,10,10,10);
    for (int k = 1; k < 8; k++) nd[k] = p4(10 + k, 10, 10, 10);
    tbl[5] = mk(p4(10,10,10,10), nd, 12, 41, 0, 1, 1, 1, 1, 2, 4);
    nd = '0; nd[0] = p4(13,10,10,10); nd[1] = p4(12,10,10,10); nd[2] = p4(11,10,10,10);
    tbl[6] = mk(p4(10,10,10,10), nd, 3, 16, 0, 1, 2, 1, 1, 1, 4);
    nd = '0;
    tbl[7] = mk(p4(255,255,255,255), nd, 1, 6, 0, 1, 0, 260100, 0, 0, 262143);
    for (int r = 8; r < 11; r++) begin
      vec_t v;
      v.x = $urandom;
      for (int k = 0; k < 8; k++) v.nodes[k] = $urandom;
      v.n = 5'($urandom_range(2, 8));
      v.th = 18'($urandom_range(0, 100000));
      tbl[r] = model(v);
    end

    rst_n = 1'b0;
    #1;
    chk("reset_state", {busy, done, mem_rd_en, mem_rd_addr, min1_node, min2_node,
                        min1_ed, min2_ed, min1_valid, min2_valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 11; r++) run(tbl[r], 1'b0, $sformatf("vec%0d", r));

    run(tbl[0], 1'b1, "start_while_busy");

    // Reset dropped while accumulating must clear everything and suppress done.
    for (int k = 0; k < 8; k++) mem[k] = tbl[0].nodes[k];
    @(negedge clk);
    x_vec = tbl[0].x; node_count = 4'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("reset_mid_acc", {busy, done, mem_rd_en, mem_rd_addr, min1_node, min2_node,
                          min1_ed, min2_ed, min1_valid, min2_valid}, 0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 0;
    repeat (20) begin @(negedge clk); if (done || busy) saw_done = 1; end
    chk("no_done_after_reset", saw_done, 0);

    run(tbl[0], 1'b0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
